tt_mem_req_responder: RTL and testbench

- Memory-side endpoint for core/VPU memory requests carried in the shared mem_skidbuf_s structure.
- Accepts one request at a time over a valid/ready handshake and drives a single-port, fixed one-cycle-latency SRAM.
- Returns load data tagged with mem_lqid to the load queue: scalar loads in one beat; vector loads merged beat-by-beat into a VLEN-wide buffer and returned once, on the last beat.

---
 rtl/tt_mem_req_responder_pkg.sv | 45 ++++
 rtl/tt_mem_ld_align.sv | 31 +++
 rtl/tt_mem_req_responder.sv | 197 +++++++++++++++++++
 tb/tb_tt_mem_req_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mem_req_responder_pkg.sv
// Shared types for the memory request responder: request/response payloads,
// responder FSM states and RISC-V load size encodings.
package tt_mem_req_responder_pkg;

    localparam int unsigned PKG_VLEN      = 256;
    localparam int unsigned PKG_MEM_DW    = 128;
    localparam int unsigned LQ_DEPTH_LOG2 = 4;
    localparam int unsigned MEM_AW        = 16;
    localparam int unsigned VLENB         = PKG_VLEN / 8;
    localparam int unsigned VIDX_W        = $clog2(VLENB);

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef struct packed {
        logic                     mem_tx_valid;
        logic                     mem_ld;
        logic                     mem_st;
        logic                     mem_fence;
        logic                     mem_amo;
        logic [MEM_AW-1:0]        mem_addr;
        logic [2:0]               mem_sz;
        logic [7:0]               mem_byten;
        logic [PKG_MEM_DW-1:0]    mem_data;
        logic [LQ_DEPTH_LOG2-1:0] mem_lqid;
        logic                     mem_lq_valid;
        logic                     mem_vec;
        logic                     vecldst_128;
        logic [VIDX_W-1:0]        vecldst_idx;
        logic [VLENB-1:0]         vecldst_byte_mask;
        logic                     vecldst_idx_last;
    } mem_skidbuf_s;

    typedef struct packed {
        logic [LQ_DEPTH_LOG2-1:0] lqid;
        logic [PKG_VLEN-1:0]      data;
        logic                     vec;
    } mem_resp_s;

    typedef enum logic [1:0] {IDLE, RD, RESP} resp_state_e;

endpackage

// File: rtl/tt_mem_ld_align.sv
// Scalar load alignment: picks the byte lane at the access offset within an SRAM
// word and sign- or zero-extends the selected byte/half/word to 32 bits.
module tt_mem_ld_align
    import tt_mem_req_responder_pkg::*;
#(
    parameter int unsigned MEM_DW = 128,
    localparam int unsigned OFF_W = $clog2(MEM_DW / 8)
) (
    input  logic [MEM_DW-1:0] rdata,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        sz,
    output logic [31:0]       data
);

    logic [31:0] lane;

    assign lane = 32'(rdata >> {off, 3'b000});

    always_comb begin
        data = lane;
        case (sz)
            SZ_B:    data = {{24{lane[7]}}, lane[7:0]};
            SZ_H:    data = {{16{lane[15]}}, lane[15:0]};
            SZ_W:    data = lane;
            SZ_BU:   data = {24'd0, lane[7:0]};
            SZ_HU:   data = {16'd0, lane[15:0]};
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/tt_mem_req_responder.sv
// Memory-side endpoint: services one request at a time against a one-cycle SRAM,
// returns scalar loads directly and accumulates vector-load beats into one response.
module tt_mem_req_responder
    import tt_mem_req_responder_pkg::*;
#(
    parameter int unsigned VLEN    = PKG_VLEN,
    parameter int unsigned MEM_DW  = PKG_MEM_DW,
    parameter int unsigned SRAM_AW = 12
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_req_vld,
    output logic                     o_req_rdy,
    input  mem_skidbuf_s             i_req,
    output logic                     o_sram_en,
    output logic                     o_sram_we,
    output logic [SRAM_AW-1:0]       o_sram_addr,
    output logic [MEM_DW-1:0]        o_sram_wdata,
    output logic [MEM_DW/8-1:0]      o_sram_wbe,
    input  logic [MEM_DW-1:0]        i_sram_rdata,
    output logic                     o_resp_vld,
    input  logic                     i_resp_rdy,
    output logic [LQ_DEPTH_LOG2-1:0] o_resp_lqid,
    output logic [VLEN-1:0]          o_resp_data,
    output logic                     o_resp_vec,
    output logic                     o_fence_done
);

    localparam int unsigned WB    = MEM_DW / 8;
    localparam int unsigned VB    = VLEN / 8;
    localparam int unsigned OFF_W = $clog2(WB);
    localparam int unsigned HALF  = MEM_DW / 2;

    resp_state_e state_q, state_d;

    logic [LQ_DEPTH_LOG2-1:0] lqid_q, vec_lqid_q;
    logic [2:0]               sz_q;
    logic [OFF_W-1:0]         off_q;
    logic [VIDX_W-1:0]        idx_q;
    logic [VB-1:0]            mask_q;
    logic                     lq_valid_q, vec_q, v128_q, last_q, amo_q;
    logic                     vec_active_q, fence_done_q;
    logic [VLEN-1:0]          vbuf_q, vbuf_merged;
    logic [31:0]              scalar_q, ld_aligned;

    logic req_fire, is_fence, is_amo, is_st, is_ld;

    assign req_fire = i_req_vld && (state_q == IDLE) && i_req.mem_tx_valid;
    assign is_fence = req_fire && i_req.mem_fence;
    assign is_amo   = req_fire && !i_req.mem_fence && i_req.mem_amo;
    assign is_st    = req_fire && !i_req.mem_fence && !i_req.mem_amo && i_req.mem_st;
    assign is_ld    = req_fire && !i_req.mem_fence && !i_req.mem_amo && !i_req.mem_st
                      && i_req.mem_ld;

    // Scalar byten is relative to the access address, so it moves with the data lane.
    logic [WB-1:0] byten_sh, vmask_sh;
    assign byten_sh = WB'(i_req.mem_byten) << i_req.mem_addr[OFF_W-1:0];
    assign vmask_sh = WB'(i_req.vecldst_byte_mask >> i_req.vecldst_idx);

    assign o_sram_en    = is_st || is_ld;
    assign o_sram_we    = is_st;
    assign o_sram_addr  = i_req.mem_addr[SRAM_AW+OFF_W-1:OFF_W];
    assign o_sram_wbe   = !is_st ? '0 : (i_req.mem_vec ? vmask_sh : byten_sh);
    assign o_sram_wdata = i_req.mem_vec ? i_req.mem_data
                                        : i_req.mem_data << {i_req.mem_addr[OFF_W-1:0], 3'b000};

    tt_mem_ld_align #(
        .MEM_DW (MEM_DW)
    ) u_ld_align (
        .rdata (i_sram_rdata),
        .off   (off_q),
        .sz    (sz_q),
        .data  (ld_aligned)
    );

    // Vector beat placement; shifting past the buffer end drops the overflow bytes.
    logic [MEM_DW-1:0] beat_data;
    logic [WB-1:0]     beat_be;
    logic [VLEN-1:0]   data_sh;
    logic [VB-1:0]     en_sh;

    assign beat_data = v128_q ? i_sram_rdata
                     : {{HALF{1'b0}}, (off_q[OFF_W-1] ? i_sram_rdata[MEM_DW-1:HALF]
                                                      : i_sram_rdata[HALF-1:0])};
    assign beat_be   = v128_q ? '1 : {{(WB/2){1'b0}}, {(WB/2){1'b1}}};
    assign data_sh   = VLEN'(beat_data) << {idx_q, 3'b000};
    assign en_sh     = (VB'(beat_be) << idx_q) & mask_q;

    always_comb begin
        vbuf_merged = (vec_active_q && (lqid_q != vec_lqid_q)) ? '0 : vbuf_q;
        for (int b = 0; b < VB; b++) begin
            if (en_sh[b]) begin
                vbuf_merged[b*8 +: 8] = data_sh[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_req_rdy  = 1'b0;
        o_resp_vld = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_req_rdy = 1'b1;
                if (is_amo) begin
                    state_d = RESP;
                end else if (is_ld) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (!lq_valid_q || (vec_q && !last_q)) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                o_resp_vld = 1'b1;
                if (i_resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lqid_q       <= '0;
            vec_lqid_q   <= '0;
            sz_q         <= '0;
            off_q        <= '0;
            idx_q        <= '0;
            mask_q       <= '0;
            lq_valid_q   <= 1'b0;
            vec_q        <= 1'b0;
            v128_q       <= 1'b0;
            last_q       <= 1'b0;
            amo_q        <= 1'b0;
            vec_active_q <= 1'b0;
            fence_done_q <= 1'b0;
            vbuf_q       <= '0;
            scalar_q     <= '0;
        end else begin
            fence_done_q <= is_fence;
            if (is_ld || is_amo) begin
                lqid_q     <= i_req.mem_lqid;
                sz_q       <= i_req.mem_sz;
                off_q      <= i_req.mem_addr[OFF_W-1:0];
                idx_q      <= i_req.vecldst_idx;
                mask_q     <= i_req.vecldst_byte_mask;
                lq_valid_q <= i_req.mem_lq_valid;
                vec_q      <= is_ld && i_req.mem_vec;
                v128_q     <= i_req.vecldst_128;
                last_q     <= i_req.vecldst_idx_last;
                amo_q      <= is_amo;
            end
            if (state_q == RD && lq_valid_q) begin
                if (vec_q) begin
                    vbuf_q       <= vbuf_merged;
                    vec_active_q <= 1'b1;
                    vec_lqid_q   <= lqid_q;
                end else begin
                    scalar_q <= ld_aligned;
                end
            end
            // Only a vector response consumes the buffer; scalar loads leave it intact.
            if (state_q == RESP && i_resp_rdy && vec_q) begin
                vbuf_q       <= '0;
                vec_active_q <= 1'b0;
            end
        end
    end

    mem_resp_s resp;

    always_comb begin
        resp.lqid = lqid_q;
        resp.vec  = vec_q;
        resp.data = vec_q ? vbuf_q : (amo_q ? '1 : {{(VLEN-32){1'b0}}, scalar_q});
    end

    assign o_resp_lqid  = resp.lqid;
    assign o_resp_data  = resp.data;
    assign o_resp_vec   = resp.vec;
    assign o_fence_done = fence_done_q;

endmodule

// File: tb/tb_tt_mem_req_responder.sv
// Directed bench for tt_mem_req_responder with a behavioural one-cycle SRAM.
module tb_tt_mem_req_responder;
    import tt_mem_req_responder_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_vld;
    logic           req_rdy;
    mem_skidbuf_s   req;
    logic           sram_en, sram_we;
    logic [11:0]    sram_addr;
    logic [127:0]   sram_wdata;
    logic [15:0]    sram_wbe;
    logic [127:0]   sram_rdata;
    logic           resp_vld, resp_rdy, resp_vec, fence_done;
    logic [3:0]     resp_lqid;
    logic [255:0]   resp_data;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [127:0] DA = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] DB = 128'h1f1e1d1c_1b1a1918_17161514_13121110;

    always #5 clk = ~clk;

    tt_mem_req_responder #(
        .VLEN    (256),
        .MEM_DW  (128),
        .SRAM_AW (12)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_vld    (req_vld),
        .o_req_rdy    (req_rdy),
        .i_req        (req),
        .o_sram_en    (sram_en),
        .o_sram_we    (sram_we),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .o_sram_wbe   (sram_wbe),
        .i_sram_rdata (sram_rdata),
        .o_resp_vld   (resp_vld),
        .i_resp_rdy   (resp_rdy),
        .o_resp_lqid  (resp_lqid),
        .o_resp_data  (resp_data),
        .o_resp_vec   (resp_vec),
        .o_fence_done (fence_done)
    );

    logic [127:0] mem [0:4095];

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 16; b++) begin
                    if (sram_wbe[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    function automatic mem_skidbuf_s mk(input logic ld, input logic st, input logic fence,
                                        input logic amo, input logic [15:0] addr,
                                        input logic [2:0] sz, input logic [7:0] byten,
                                        input logic [127:0] data, input logic [3:0] lqid,
                                        input logic lqv, input logic vec, input logic [4:0] idx,
                                        input logic [31:0] mask, input logic last);
        mem_skidbuf_s r;
        r = '0;
        r.mem_tx_valid      = 1'b1;
        r.mem_ld            = ld;
        r.mem_st            = st;
        r.mem_fence         = fence;
        r.mem_amo           = amo;
        r.mem_addr          = addr;
        r.mem_sz            = sz;
        r.mem_byten         = byten;
        r.mem_data          = data;
        r.mem_lqid          = lqid;
        r.mem_lq_valid      = lqv;
        r.mem_vec           = vec;
        r.vecldst_128       = vec;
        r.vecldst_idx       = idx;
        r.vecldst_byte_mask = mask;
        r.vecldst_idx_last  = last;
        return r;
    endfunction

    function automatic mem_skidbuf_s vld(input logic [15:0] addr, input logic [3:0] lqid,
                                         input logic [4:0] idx, input logic [31:0] mask,
                                         input logic last);
        return mk(1, 0, 0, 0, addr, 3'd0, 8'h0, '0, lqid, 1, 1, idx, mask, last);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input mem_skidbuf_s r);
        req     = r;
        req_vld = 1'b1;
        tick();
        req_vld = 1'b0;
        req     = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_vld = 1'b0; req = '0; resp_rdy = 1'b1;
        #3;
        n_chk++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy got %b want 1", req_rdy); end
        n_chk++; if (resp_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", resp_vld); end
        n_chk++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %b want 0", sram_en); end
        n_chk++; if (fence_done !== 1'b0) begin n_err++; $display("FAIL reset_fence got %b want 0", fence_done); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store();
        req = mk(0, 1, 0, 0, 16'h0104, SZ_W, 8'h0F, 128'h800000F0, 0, 0, 0, 0, 0, 0);
        req_vld = 1'b1;
        #1;
        n_chk++; if ({sram_en, sram_we} !== 2'b11) begin n_err++; $display("FAIL st_en_we got %b want 11", {sram_en, sram_we}); end
        n_chk++; if (sram_wbe !== 16'h00F0) begin n_err++; $display("FAIL st_wbe got %h want 00f0", sram_wbe); end
        n_chk++; if (sram_addr !== 12'h010) begin n_err++; $display("FAIL st_addr got %h want 010", sram_addr); end
        n_chk++; if (sram_wdata[63:32] !== 32'h800000F0) begin n_err++; $display("FAIL st_wdata got %h want 800000f0", sram_wdata[63:32]); end
        tick();
        req_vld = 1'b0;
        n_chk++; if (req_rdy !== 1'b1) begin n_err++; $display("FAIL st_stay_idle got %b want 1", req_rdy); end
        send(mk(0, 1, 0, 0, 16'h0200, 3'd0, 8'h0, DA, 0, 0, 1, 0, 32'hFFFFFFFF, 0));
        send(mk(0, 1, 0, 0, 16'h0210, 3'd0, 8'h0, DB, 0, 0, 1, 0, 32'hFFFFFFFF, 0));
    endtask

    task automatic test_scalar_load();
        logic [15:0] addrs [6] = '{16'h0104, 16'h0104, 16'h0104, 16'h0106, 16'h0106, 16'h0107};
        logic [2:0]  szs   [6] = '{SZ_B, SZ_BU, SZ_W, SZ_H, SZ_HU, SZ_B};
        logic [31:0] exps  [6] = '{32'hFFFFFFF0, 32'h000000F0, 32'h800000F0,
                                   32'hFFFF8000, 32'h00008000, 32'hFFFFFF80};
        for (int i = 0; i < 6; i++) begin
            send(mk(1, 0, 0, 0, addrs[i], szs[i], 8'h0, '0, 4'(i + 3), 1, 0, 0, 0, 0));
            n_chk++; if ({resp_vld, req_rdy} !== 2'b00) begin n_err++; $display("FAIL ld%0d_rd got %b want 00", i, {resp_vld, req_rdy}); end
            tick();
            n_chk++; if ({resp_vld, resp_vec, resp_lqid} !== {2'b10, 4'(i + 3)}) begin n_err++; $display("FAIL ld%0d_ctl got %b want %b", i, {resp_vld, resp_vec, resp_lqid}, {2'b10, 4'(i + 3)}); end
            n_chk++; if (resp_data !== {224'd0, exps[i]}) begin n_err++; $display("FAIL ld%0d_data got %h want %h", i, resp_data, exps[i]); end
            tick();
            n_chk++; if ({resp_vld, req_rdy} !== 2'b01) begin n_err++; $display("FAIL ld%0d_done got %b want 01", i, {resp_vld, req_rdy}); end
        end
    endtask

    task automatic test_vector();
        send(vld(16'h0200, 5, 0, 32'hFFFFFFFF, 0));
        tick();
        n_chk++; if ({resp_vld, req_rdy} !== 2'b01) begin n_err++; $display("FAIL vec_beat0 got %b want 01", {resp_vld, req_rdy}); end
        send(vld(16'h0210, 5, 16, 32'hFFFFFFFF, 1));
        tick();
        n_chk++; if ({resp_vld, resp_vec, resp_lqid} !== 6'b11_0101) begin n_err++; $display("FAIL vec_ctl got %b want 110101", {resp_vld, resp_vec, resp_lqid}); end
        n_chk++; if (resp_data !== {DB, DA}) begin n_err++; $display("FAIL vec_data got %h want %h", resp_data, {DB, DA}); end
        tick();
        send(vld(16'h0200, 6, 0, 32'h0000000F, 1));
        tick();
        n_chk++; if (resp_data !== {224'd0, 32'h03020100}) begin n_err++; $display("FAIL vec_mask got %h want 03020100", resp_data); end
        tick();
        send(vld(16'h0210, 7, 24, 32'hFFFFFFFF, 1));
        tick();
        n_chk++; if (resp_data !== {64'h17161514_13121110, 192'd0}) begin n_err++; $display("FAIL vec_trunc got %h", resp_data); end
        tick();
        send(vld(16'h0200, 8, 0, 32'hFFFFFFFF, 0));
        tick();
        send(vld(16'h0210, 9, 16, 32'hFFFFFFFF, 1));
        tick();
        n_chk++; if ({resp_lqid, resp_data} !== {4'd9, DB, 128'd0}) begin n_err++; $display("FAIL vec_restart got %h/%h want 9/%h", resp_lqid, resp_data, {DB, 128'd0}); end
        tick();
    endtask

    task automatic test_scalar_during_vec();
        send(vld(16'h0200, 10, 0, 32'hFFFFFFFF, 0));
        tick();
        send(mk(1, 0, 0, 0, 16'h0104, SZ_W, 8'h0, '0, 11, 1, 0, 0, 0, 0));
        tick();
        n_chk++; if ({resp_vec, resp_lqid, resp_data} !== {1'b0, 4'd11, 224'd0, 32'h800000F0}) begin n_err++; $display("FAIL mix_scalar got %b/%h/%h want 0/b/800000f0", resp_vec, resp_lqid, resp_data); end
        tick();
        send(vld(16'h0210, 10, 16, 32'hFFFFFFFF, 1));
        tick();
        n_chk++; if ({resp_lqid, resp_data} !== {4'd10, DB, DA}) begin n_err++; $display("FAIL mix_vec got %h/%h want a/%h", resp_lqid, resp_data, {DB, DA}); end
        tick();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        resp_rdy = 1'b0;
        send(mk(1, 0, 0, 0, 16'h0104, SZ_W, 8'h0, '0, 2, 1, 0, 0, 0, 0));
        tick();
        for (int i = 0; i < 5; i++) begin
            if ({resp_vld, req_rdy} !== 2'b10 || resp_data !== {224'd0, 32'h800000F0}) bad++;
            tick();
        end
        n_chk++; if (bad != 0) begin n_err++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        resp_rdy = 1'b1;
        tick();
        n_chk++; if ({resp_vld, req_rdy} !== 2'b01) begin n_err++; $display("FAIL bp_release got %b want 01", {resp_vld, req_rdy}); end
    endtask

    task automatic test_fence_amo();
        n_chk++; if (fence_done !== 1'b0) begin n_err++; $display("FAIL fence_pre got %b want 0", fence_done); end
        send(mk(0, 0, 1, 0, 16'h0, 3'd0, 8'h0, '0, 0, 0, 0, 0, 0, 0));
        n_chk++; if ({fence_done, req_rdy} !== 2'b11) begin n_err++; $display("FAIL fence_pulse got %b want 11", {fence_done, req_rdy}); end
        tick();
        n_chk++; if (fence_done !== 1'b0) begin n_err++; $display("FAIL fence_end got %b want 0", fence_done); end
        send(mk(0, 0, 0, 1, 16'h0104, SZ_W, 8'h0, '0, 1, 1, 0, 0, 0, 0));
        n_chk++; if ({resp_vld, resp_vec, resp_lqid} !== 6'b10_0001) begin n_err++; $display("FAIL amo_ctl got %b want 100001", {resp_vld, resp_vec, resp_lqid}); end
        n_chk++; if (resp_data !== {256{1'b1}}) begin n_err++; $display("FAIL amo_data got %h want all ones", resp_data); end
        tick();
        n_chk++; if (resp_vld !== 1'b0) begin n_err++; $display("FAIL amo_done got %b want 0", resp_vld); end
    endtask

    task automatic test_drops();
        req = mk(1, 0, 0, 0, 16'h0104, SZ_W, 8'h0, '0, 12, 1, 0, 0, 0, 0);
        req.mem_tx_valid = 1'b0;
        req_vld = 1'b1;
        #1;
        n_chk++; if (sram_en !== 1'b0) begin n_err++; $display("FAIL txinv_en got %b want 0", sram_en); end
        tick();
        req_vld = 1'b0;
        n_chk++; if ({resp_vld, req_rdy} !== 2'b01) begin n_err++; $display("FAIL txinv_idle got %b want 01", {resp_vld, req_rdy}); end
        send(mk(1, 0, 0, 0, 16'h0104, SZ_W, 8'h0, '0, 12, 0, 0, 0, 0, 0));
        n_chk++; if (req_rdy !== 1'b0) begin n_err++; $display("FAIL nolq_rd got %b want 0", req_rdy); end
        tick();
        tick();
        n_chk++; if ({resp_vld, req_rdy} !== 2'b01) begin n_err++; $display("FAIL nolq_noresp got %b want 01", {resp_vld, req_rdy}); end
    endtask

    task automatic test_reset_mid();
        send(mk(1, 0, 0, 0, 16'h0104, SZ_W, 8'h0, '0, 13, 1, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if ({req_rdy, resp_vld, sram_en} !== 3'b100) begin n_err++; $display("FAIL rstmid_now got %b want 100", {req_rdy, resp_vld, sram_en}); end
        #1;
        rst = 1'b0;
        tick();
        tick();
        tick();
        n_chk++; if ({resp_vld, req_rdy} !== 2'b01) begin n_err++; $display("FAIL rstmid_stale got %b want 01", {resp_vld, req_rdy}); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_scalar_load();
        test_vector();
        test_scalar_during_vec();
        test_backpressure();
        test_fence_amo();
        test_drops();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
